// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flagged synchronous FIFO.
// Optional FWFT read mode is selected with SYNC_FIFO_FWFT_EN.
package sync_fifo_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit cfg_ok(
    input int depth,
    input int aempty,
    input int afull
  );
    return (depth >= 2)
      && ((depth & (depth - 1)) == 0)
      && (aempty < afull)
      && (afull <= depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } flags_t;

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Write/read/status bundle of the flagged synchronous FIFO.
// The FIFO takes the slave side, the user takes the master side.
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) ();
  import sync_fifo_pkg::*;

  localparam int CW = ptr_w(DEPTH);

  logic                  w_en_i;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en_i;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic [CW-1:0]         count_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output w_en_i, data_in, r_en_i,
    input  data_out, full_o, empty_o,
    input  almost_full_o, almost_empty_o,
    input  count_o, overflow_o, underflow_o
  );

  modport slave (
    input  w_en_i, data_in, r_en_i,
    output data_out, full_o, empty_o,
    output almost_full_o, almost_empty_o,
    output count_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/sync_fifo_ptr.sv
// Wrap-bit FIFO pointer: low bits address memory, MSB is the lap bit.
// Free-running binary increment; DEPTH is a power of two.
module sync_fifo_ptr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] ptr_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else if (en_i) begin
      ptr_o <= ptr_o + W'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO using all DEPTH entries, with count and flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input logic            clk_i,
  input logic            rst_i,
  sync_fifo_flags_if.slave bus
);

  localparam int CW = ptr_w(DEPTH);
  localparam int AW = CW - 1;

  if (!cfg_ok(DEPTH, AEMPTY_THRESH, AFULL_THRESH)) begin : g_bad_cfg
    $error("sync_fifo_flags: invalid DEPTH or thresholds");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         wr_ptr;
  logic [CW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  ovf_q;
  logic                  udf_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  flags_t                fl;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  always_comb begin
    fl        = '0;
    fl.empty  = (wr_ptr == rd_ptr);
    fl.full   = (wr_addr == rd_addr)
             && (wr_ptr[AW] != rd_ptr[AW]);
    fl.afull  = (cnt >= CW'(AFULL_THRESH));
    fl.aempty = (cnt <= CW'(AEMPTY_THRESH));
    fl.ovf    = ovf_q;
    fl.udf    = udf_q;
  end

  // Accept decisions look only at registered state.
  assign wr_acc = bus.w_en_i && !fl.full;
  assign rd_acc = bus.r_en_i && !fl.empty;

  sync_fifo_ptr #(.W(CW)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (wr_acc),
    .ptr_o (wr_ptr)
  );

  sync_fifo_ptr #(.W(CW)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (rd_acc),
    .ptr_o (rd_ptr)
  );

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem[wr_addr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt   <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (bus.w_en_i && fl.full)  ovf_q <= 1'b1;
      if (bus.r_en_i && fl.empty) udf_q <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.data_out = fl.empty ? '0 : mem[rd_addr];
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= '0;
    end else if (rd_acc) begin
      dout_q <= mem[rd_addr];
    end
  end

  assign bus.data_out = dout_q;
`endif

  assign bus.full_o         = fl.full;
  assign bus.empty_o        = fl.empty;
  assign bus.almost_full_o  = fl.afull;
  assign bus.almost_empty_o = fl.aempty;
  assign bus.count_o        = cnt;
  assign bus.overflow_o     = fl.ovf;
  assign bus.underflow_o    = fl.udf;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised bench for sync_fifo_flags against a queue-based model.
// Follows SYNC_FIFO_FWFT_EN to pick the expected read timing.
module tb_sync_fifo_flags;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) f ();

  sync_fifo_flags #(
    .DEPTH         (DEPTH),
    .DATA_WIDTH    (DW),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (f)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf  = 1'b0;
  bit            m_udf  = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    int sz;
    logic [DW-1:0] ed;
    sz = q.size();
`ifdef SYNC_FIFO_FWFT_EN
    ed = (sz > 0) ? q[0] : '0;
`else
    ed = m_dout;
`endif
    chk({tag, ".cnt"},   32'(f.count_o),      32'(sz));
    chk({tag, ".full"},  32'(f.full_o),       32'(sz == DEPTH));
    chk({tag, ".empty"}, 32'(f.empty_o),      32'(sz == 0));
    chk({tag, ".afull"}, 32'(f.almost_full_o), 32'(sz >= AF));
    chk({tag, ".aemp"},  32'(f.almost_empty_o), 32'(sz <= AE));
    chk({tag, ".ovf"},   32'(f.overflow_o),   32'(m_ovf));
    chk({tag, ".udf"},   32'(f.underflow_o),  32'(m_udf));
    chk({tag, ".dout"},  32'(f.data_out),     32'(ed));
  endtask

  task automatic step(input string tag, input bit w, input bit r,
                      input logic [DW-1:0] d, input bit rs);
    int  sz;
    bit  wa;
    bit  ra;
    logic [DW-1:0] hd;
    f.w_en_i  = w;
    f.r_en_i  = r;
    f.data_in = d;
    rst       = rs;
    @(posedge clk);
    if (rs) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      sz = q.size();
      wa = w && (sz < DEPTH);
      ra = r && (sz > 0);
      if (w && sz == DEPTH) m_ovf = 1'b1;
      if (r && sz == 0)     m_udf = 1'b1;
      if (ra) begin
        hd = q.pop_front();
        m_dout = hd;
      end
      if (wa) q.push_back(d);
    end
    #1;
    chk_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    f.w_en_i  = 1'b0;
    f.r_en_i  = 1'b0;
    f.data_in = '0;
    step("rst", 0, 0, 8'h00, 1);
    step("rst", 0, 0, 8'h00, 1);

    for (int i = 1; i <= DEPTH; i++)
      step("fill", 1, 0, DW'(i), 0);
    chk("fill_cnt8", 32'(f.count_o), 32'd8);
    step("ovf", 1, 0, 8'hEE, 0);
    chk("ovf_set", 32'(f.overflow_o), 32'd1);
    for (int i = 0; i < DEPTH; i++)
      step("drain", 0, 1, 8'h00, 0);
    chk("drain_empty", 32'(f.empty_o), 32'd1);
    step("udf", 0, 1, 8'h00, 0);
    chk("udf_set", 32'(f.underflow_o), 32'd1);

    step("rst2", 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++)
      step("pre4", 1, 0, DW'(8'h10 + i), 0);
    for (int i = 0; i < 20; i++)
      step("rw4", 1, 1, DW'(8'h20 + i), 0);
    chk("rw4_cnt", 32'(f.count_o), 32'd4);
    for (int i = 0; i < 4; i++)
      step("top8", 1, 0, DW'(8'h40 + i), 0);
    step("rwfull", 1, 1, 8'hBB, 0);
    chk("rwfull_cnt7", 32'(f.count_o), 32'd7);

    step("rst3", 0, 0, 8'h00, 1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++)
        step("wrap_w", 1, 0, DW'(8'h50 + 8 * k + i), 0);
      for (int i = 0; i < 5; i++)
        step("wrap_r", 0, 1, 8'h00, 0);
    end

    for (int i = 0; i < 5; i++)
      step("mid5", 1, 0, DW'(8'h60 + i), 0);
    step("midrst", 1, 0, 8'h77, 1);
    chk("midrst_cnt", 32'(f.count_o), 32'd0);
    chk("midrst_dout", 32'(f.data_out), 32'd0);

    step("lat_w", 1, 0, 8'hA5, 0);
    step("lat_idle", 0, 0, 8'h00, 0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("lat_fwft", 32'(f.data_out), 32'hA5);
`endif
    step("lat_r", 0, 1, 8'h00, 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("lat_reg", 32'(f.data_out), 32'hA5);
`endif

    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 100; i++) begin
        int  pw;
        bit  w;
        bit  r;
        bit  rs;
        pw = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
        w  = ($urandom_range(0, 99) < pw);
        r  = ($urandom_range(0, 99) < (100 - pw));
        rs = ($urandom_range(0, 149) == 0);
        step("rnd", w, r, DW'($urandom), rs);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
